// File: rtl/idu_dispatch_queue_pkg.sv
// Shared constants for the decode-to-execute dispatch queue: payload field layout,
// register-address width and default depth.
package idu_dispatch_queue_pkg;

  localparam int REG_AW    = 5;
  localparam int DEPTH_DEF = 2;

  localparam int REGWR_W   = 1;
  localparam int INTREN_W  = 1;
  localparam int ISSEXT_W  = 1;
  localparam int ISTRUNC_W = 1;
  localparam int REGSRC_W  = 8;
  localparam int MEMOP_W   = 11;
  localparam int MEMWR_W   = 1;
  localparam int BRANCH_W  = 16;
  localparam int ALUBSR_W  = 4;
  localparam int ALUASR_W  = 2;
  localparam int ALUCT_W   = 32;
  localparam int RS2_W     = 32;
  localparam int RS1_W     = 32;
  localparam int IMM_W     = 32;
  localparam int PC_W      = 32;
  localparam int INST_W    = 32;

  // Control bits sit in the low end, operands and inst in the high end.
  localparam int REGWR_LSB   = 0;
  localparam int INTREN_LSB  = REGWR_LSB   + REGWR_W;
  localparam int ISSEXT_LSB  = INTREN_LSB  + INTREN_W;
  localparam int ISTRUNC_LSB = ISSEXT_LSB  + ISSEXT_W;
  localparam int REGSRC_LSB  = ISTRUNC_LSB + ISTRUNC_W;
  localparam int MEMOP_LSB   = REGSRC_LSB  + REGSRC_W;
  localparam int MEMWR_LSB   = MEMOP_LSB   + MEMOP_W;
  localparam int BRANCH_LSB  = MEMWR_LSB   + MEMWR_W;
  localparam int ALUBSR_LSB  = BRANCH_LSB  + BRANCH_W;
  localparam int ALUASR_LSB  = ALUBSR_LSB  + ALUBSR_W;
  localparam int ALUCT_LSB   = ALUASR_LSB  + ALUASR_W;
  localparam int RS2_LSB     = ALUCT_LSB   + ALUCT_W;
  localparam int RS1_LSB     = RS2_LSB     + RS2_W;
  localparam int IMM_LSB     = RS1_LSB     + RS1_W;
  localparam int PC_LSB      = IMM_LSB     + IMM_W;
  localparam int INST_LSB    = PC_LSB      + PC_W;
  localparam int PW_DEF      = INST_LSB    + INST_W;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Pointer width that stays legal for a single-entry queue.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/idu_dispatch_queue_if.sv
// Decoder-side offer, EXU-side head and witf push signals of the dispatch queue.
interface idu_dispatch_queue_if
  import idu_dispatch_queue_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = 2
);
  logic          ifu_valid;
  logic          idu_ready;
  logic [PW-1:0] in_payload;
  reg_addr_t     in_rd;
  logic          in_regwr;
  logic          isRAW;
  logic          witf_full;
  logic          flush;
  logic          idu_valid;
  logic          exu_ready;
  logic [PW-1:0] out_payload;
  logic          witf_push;
  reg_addr_t     witf_rd;
  logic [CW-1:0] count;

  modport master (
    output ifu_valid, in_payload, in_rd, in_regwr, isRAW, witf_full, flush, exu_ready,
    input  idu_ready, idu_valid, out_payload, witf_push, witf_rd, count
  );

  modport slave (
    input  ifu_valid, in_payload, in_rd, in_regwr, isRAW, witf_full, flush, exu_ready,
    output idu_ready, idu_valid, out_payload, witf_push, witf_rd, count
  );
endinterface

// File: rtl/idu_dispatch_queue_idq_ram.sv
// DEPTH x PW entry storage: one write port, one asynchronous read port, cleared on reset.
module idq_ram #(
  parameter int DEPTH = 2,
  parameter int PW    = 238,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);
  logic [DEPTH-1:0][PW-1:0] mem;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    always_ff @(posedge clk) begin
      if (rst)                          mem[e] <= '0;
      else if (we && waddr == AW'(e))   mem[e] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/idu_dispatch_queue.sv
// In-order decode-to-execute dispatch buffer with RAW/witf stall, flush and witf push.
module idu_dispatch_queue
  import idu_dispatch_queue_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  idu_dispatch_queue_if.slave bus
);
  localparam int AW = ptr_w(DEPTH);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rdata;
  logic          enq, deq, not_full;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A full queue may still accept when the head leaves in the same cycle.
  assign not_full      = cnt < CW'(DEPTH);
  assign bus.idu_ready = !bus.flush && !bus.isRAW && !bus.witf_full && (not_full || bus.exu_ready);
  assign bus.idu_valid = cnt != '0;
  assign enq           = bus.ifu_valid && bus.idu_ready;
  assign deq           = bus.idu_valid && bus.exu_ready && !bus.flush;

  assign bus.witf_push   = enq && bus.in_regwr;
  assign bus.witf_rd     = bus.in_rd;
  assign bus.count       = cnt;
  assign bus.out_payload = rdata;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  idq_ram #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (bus.in_payload),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_idu_dispatch_queue.sv
// Scoreboard bench for idu_dispatch_queue at DEPTH=2 and DEPTH=4.
module tb_idu_dispatch_queue;
  import idu_dispatch_queue_pkg::*;

  localparam int PW = PW_DEF;
  typedef logic [PW-1:0] pl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  pl_t  sb2[$], obs2[$], sb4[$], obs4[$];

  always #5 clk = ~clk;

  idu_dispatch_queue_if #(.PW(PW), .CW(2)) b2 ();
  idu_dispatch_queue_if #(.PW(PW), .CW(3)) b4 ();

  idu_dispatch_queue #(.PW(PW), .DEPTH(2), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  idu_dispatch_queue #(.PW(PW), .DEPTH(4), .CW(3)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  // Record accepted offers as expectations and departing heads as observations, then advance.
  task automatic tick2();
    #1;
    if (b2.ifu_valid && b2.idu_ready) sb2.push_back(b2.in_payload);
    if (b2.idu_valid && b2.exu_ready && !b2.flush) obs2.push_back(b2.out_payload);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer2(input int p);
    b2.ifu_valid  = 1'b1;
    b2.in_payload = PW'(p);
  endtask

  task automatic test_reset();
    {b2.ifu_valid, b2.in_regwr, b2.isRAW, b2.witf_full, b2.flush, b2.exu_ready} = '0;
    {b4.ifu_valid, b4.in_regwr, b4.isRAW, b4.witf_full, b4.flush, b4.exu_ready} = '0;
    b2.in_payload = '0; b2.in_rd = '0; b4.in_payload = '0; b4.in_rd = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (b2.count !== 2'd0) $display("FAIL reset_count: got %0d want 0", b2.count); else passed++;
    total++; if (b2.idu_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", b2.idu_valid); else passed++;
    total++; if (b2.idu_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", b2.idu_ready); else passed++;
    total++; if (b2.witf_push !== 1'b0) $display("FAIL reset_push: got %b want 0", b2.witf_push); else passed++;
    total++; if (b2.out_payload !== '0) $display("FAIL reset_payload: got %h want 0", b2.out_payload); else passed++;
    total++; if (b4.count !== 3'd0 || b4.idu_valid !== 1'b0) $display("FAIL reset_d4: got count %0d valid %b want 0 0", b4.count, b4.idu_valid); else passed++;
  endtask

  task automatic test_fill_drain();
    pl_t e, g;
    b2.exu_ready = 1'b0;
    offer2('hA); tick2();
    offer2('hB); tick2();
    offer2('hC); #1;
    total++; if (b2.count !== 2'd2) $display("FAIL fill_count: got %0d want 2", b2.count); else passed++;
    total++; if (b2.idu_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", b2.idu_ready); else passed++;
    total++; if (b2.out_payload !== PW'('hA)) $display("FAIL fill_head: got %h want a", b2.out_payload); else passed++;
    b2.ifu_valid = 1'b0; b2.exu_ready = 1'b1;
    tick2(); tick2(); #1;
    total++; if (b2.idu_valid !== 1'b0 || b2.count !== 2'd0) $display("FAIL drain_empty: got valid %b count %0d want 0 0", b2.idu_valid, b2.count); else passed++;
    total++; if (obs2.size() != 2 || sb2.size() != 2) $display("FAIL drain_n: got %0d out %0d in want 2 2", obs2.size(), sb2.size()); else passed++;
    while (obs2.size() > 0 && sb2.size() > 0) begin
      e = sb2.pop_front(); g = obs2.pop_front();
      total++; if (g !== e) $display("FAIL drain_order: got %h want %h", g, e); else passed++;
    end
    sb2.delete(); obs2.delete();
    b2.exu_ready = 1'b0;
  endtask

  task automatic test_full_simul();
    pl_t e, g;
    offer2('h11); tick2();
    offer2('h12); tick2();
    b2.exu_ready = 1'b1; offer2('hC); #1;
    total++; if (b2.idu_ready !== 1'b1) $display("FAIL simul_ready: got %b want 1", b2.idu_ready); else passed++;
    tick2();
    b2.ifu_valid = 1'b0; #1;
    total++; if (b2.count !== 2'd2) $display("FAIL simul_count: got %0d want 2", b2.count); else passed++;
    tick2(); tick2(); #1;
    total++; if (b2.count !== 2'd0) $display("FAIL simul_drain: got %0d want 0", b2.count); else passed++;
    total++; if (obs2.size() != 3 || sb2.size() != 3) $display("FAIL simul_n: got %0d out %0d in want 3 3", obs2.size(), sb2.size()); else passed++;
    while (obs2.size() > 0 && sb2.size() > 0) begin
      e = sb2.pop_front(); g = obs2.pop_front();
      total++; if (g !== e) $display("FAIL simul_order: got %h want %h", g, e); else passed++;
    end
    sb2.delete(); obs2.delete();
    b2.exu_ready = 1'b0;
  endtask

  task automatic test_hazard();
    pl_t e, g;
    b2.in_regwr = 1'b0;
    offer2('h21); tick2();
    b2.isRAW = 1'b1; b2.in_regwr = 1'b1; b2.in_rd = 5'd5; b2.exu_ready = 1'b1;
    offer2('h22); #1;
    total++; if (b2.idu_ready !== 1'b0) $display("FAIL raw_ready: got %b want 0", b2.idu_ready); else passed++;
    total++; if (b2.witf_push !== 1'b0) $display("FAIL raw_push: got %b want 0", b2.witf_push); else passed++;
    tick2(); #1;
    total++; if (b2.count !== 2'd0) $display("FAIL raw_drain: got %0d want 0", b2.count); else passed++;
    b2.isRAW = 1'b0; #1;
    total++; if (b2.witf_push !== 1'b1 || b2.witf_rd !== 5'd5) $display("FAIL raw_release_push: got %b rd %0d want 1 rd 5", b2.witf_push, b2.witf_rd); else passed++;
    tick2();
    b2.ifu_valid = 1'b0; b2.in_regwr = 1'b0; #1;
    total++; if (b2.idu_valid !== 1'b1 || b2.out_payload !== PW'('h22)) $display("FAIL raw_latency: got valid %b head %h want 1 22", b2.idu_valid, b2.out_payload); else passed++;
    total++; if (b2.witf_push !== 1'b0) $display("FAIL raw_push_idle: got %b want 0", b2.witf_push); else passed++;
    tick2();
    total++; if (obs2.size() != 2 || sb2.size() != 2) $display("FAIL raw_n: got %0d out %0d in want 2 2", obs2.size(), sb2.size()); else passed++;
    while (obs2.size() > 0 && sb2.size() > 0) begin
      e = sb2.pop_front(); g = obs2.pop_front();
      total++; if (g !== e) $display("FAIL raw_order: got %h want %h", g, e); else passed++;
    end
    sb2.delete(); obs2.delete();
    b2.exu_ready = 1'b0;
  endtask

  task automatic test_flush();
    pl_t e, g;
    offer2('h30); tick2();
    offer2('h31); tick2();
    b2.exu_ready = 1'b1; offer2('h32); tick2();
    b2.flush = 1'b1; b2.in_regwr = 1'b1; b2.in_rd = 5'd7; offer2('h33); #1;
    total++; if (b2.idu_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", b2.idu_ready); else passed++;
    total++; if (b2.witf_push !== 1'b0) $display("FAIL flush_push: got %b want 0", b2.witf_push); else passed++;
    tick2();
    sb2.delete(); obs2.delete();
    b2.flush = 1'b0; b2.exu_ready = 1'b0; b2.in_regwr = 1'b0;
    offer2('hD); #1;
    total++; if (b2.count !== 2'd0 || b2.idu_valid !== 1'b0) $display("FAIL flush_empty: got count %0d valid %b want 0 0", b2.count, b2.idu_valid); else passed++;
    tick2();
    b2.ifu_valid = 1'b0; #1;
    total++; if (b2.idu_valid !== 1'b1 || b2.out_payload !== PW'('hD)) $display("FAIL flush_next: got valid %b head %h want 1 d", b2.idu_valid, b2.out_payload); else passed++;
    b2.exu_ready = 1'b1; tick2();
    total++; if (obs2.size() != 1 || sb2.size() != 1) $display("FAIL flush_n: got %0d out %0d in want 1 1", obs2.size(), sb2.size()); else passed++;
    while (obs2.size() > 0 && sb2.size() > 0) begin
      e = sb2.pop_front(); g = obs2.pop_front();
      total++; if (g !== e) $display("FAIL flush_order: got %h want %h", g, e); else passed++;
    end
    sb2.delete(); obs2.delete();
    b2.exu_ready = 1'b0;
  endtask

  task automatic test_midreset();
    offer2('h41); tick2();
    b2.ifu_valid = 1'b0; #1;
    total++; if (b2.count !== 2'd1) $display("FAIL mrst_pre: got %0d want 1", b2.count); else passed++;
    rst = 1'b1; b2.flush = 1'b1;
    tick2();
    rst = 1'b0; b2.flush = 1'b0; #1;
    total++; if (b2.count !== 2'd0 || b2.idu_valid !== 1'b0) $display("FAIL mrst_empty: got count %0d valid %b want 0 0", b2.count, b2.idu_valid); else passed++;
    total++; if (b2.out_payload !== '0) $display("FAIL mrst_storage: got %h want 0", b2.out_payload); else passed++;
    sb2.delete(); obs2.delete();
  endtask

  task automatic test_back_to_back();
    pl_t e, g;
    b2.exu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      offer2('h50 + i); #1;
      total++; if (b2.idu_ready !== 1'b1 || b2.count > 2'd1) $display("FAIL b2b_flow %0d: got ready %b count %0d want 1 <=1", i, b2.idu_ready, b2.count); else passed++;
      tick2();
    end
    b2.ifu_valid = 1'b0;
    tick2();
    total++; if (obs2.size() != 6 || sb2.size() != 6) $display("FAIL b2b_n: got %0d out %0d in want 6 6", obs2.size(), sb2.size()); else passed++;
    while (obs2.size() > 0 && sb2.size() > 0) begin
      e = sb2.pop_front(); g = obs2.pop_front();
      total++; if (g !== e) $display("FAIL b2b_order: got %h want %h", g, e); else passed++;
    end
    sb2.delete(); obs2.delete();
    b2.exu_ready = 1'b0;
  endtask

  task automatic test_wrap();
    pl_t e, g;
    int sent = 0;
    int cyc  = 0;
    while ((sent < 10 || b4.count != 3'd0) && cyc < 300) begin
      b4.ifu_valid  = (sent < 10);
      b4.in_payload = PW'(256 + sent);
      b4.exu_ready  = 1'($urandom_range(0, 1));
      #1;
      total++; if (b4.count > 3'd4) $display("FAIL wrap_count: got %0d want <=4", b4.count); else passed++;
      if (b4.ifu_valid && b4.idu_ready) begin
        sb4.push_back(b4.in_payload);
        sent++;
      end
      if (b4.idu_valid && b4.exu_ready) obs4.push_back(b4.out_payload);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    b4.ifu_valid = 1'b0; b4.exu_ready = 1'b0;
    total++; if (cyc >= 300) $display("FAIL wrap_timeout: got %0d cycles want <300", cyc); else passed++;
    total++; if (obs4.size() != 10 || sb4.size() != 10) $display("FAIL wrap_n: got %0d out %0d in want 10 10", obs4.size(), sb4.size()); else passed++;
    while (obs4.size() > 0 && sb4.size() > 0) begin
      e = sb4.pop_front(); g = obs4.pop_front();
      total++; if (g !== e) $display("FAIL wrap_order: got %h want %h", g, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_hazard();
    test_flush();
    test_midreset();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/idu_dispatch_queue.md
# idu_dispatch_queue

Parametrised decode-to-execute dispatch buffer that replaces the single-entry ID/EX pipeline register. It sits between the decoder (ContrGen output plus operand values, packed into one payload word) and the EXU. It holds up to DEPTH decoded instructions in order, stalls on RAW hazard or a full write-in-flight table (witf), and supports a single-cycle flush for branch/trap redirect. It also generates the witf push for every accepted instruction.

## Interface
Parameters:
- PW, 238: payload width in bits (inst, pc, Imm, R_rs1, R_rs2, ALUct, ALUAsr, ALUBsr, Branch, MemWr, MemOP, RegSrc, isTuncate, isSext, IntrEn, RegWr, packed by the decoder side).
- DEPTH, 2: number of entries; power of two, 1..8.
- CW, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_valid  in  1  decoder/IFU offers an instruction.
- idu_ready  out  1  instruction is accepted this cycle when ifu_valid & idu_ready.
- in_payload  in  PW  decoded payload.
- in_rd  in  5  destination register of the offered instruction.
- in_regwr  in  1  offered instruction writes rd.
- isRAW  in  1  scoreboard reports a RAW hazard for the offered instruction.
- witf_full  in  1  witf cannot take another entry.
- flush  in  1  discard all buffered and offered instructions.
- idu_valid  out  1  head entry is valid.
- exu_ready  in  1  EXU takes the head when idu_valid & exu_ready.
- out_payload  out  PW  head entry payload.
- witf_push  out  1  one-cycle strobe: an instruction with in_regwr=1 was accepted.
- witf_rd  out  5  rd for witf_push.
- count  out  CW  current occupancy.

## Operation
- Circular buffer with read pointer, write pointer (log2(DEPTH) bits, wrap modulo DEPTH), and count.
- Definitions: enq = ifu_valid & idu_ready; deq = idu_valid & exu_ready & !flush.
- idu_ready = !flush & !isRAW & !witf_full & ((count < DEPTH) | exu_ready). The exu_ready term lets a full buffer accept while the head drains in the same cycle.
- idu_valid = (count != 0). out_payload = entry[rd_ptr]. Its value is don't-care when count=0, but it must hold its last value and not X.
- Simultaneous enq and deq: the head is removed, the new entry is written at wr_ptr, and count is unchanged. At count=DEPTH this is the only legal way to enqueue.
- flush has priority over everything. Next cycle: count=0, rd_ptr=wr_ptr=0, and no enqueue occurs because idu_ready=0 during flush. Entry storage is not cleared.
- witf_push = enq & in_regwr, with witf_rd = in_rd. Both are combinational in the enq cycle, so the witf sees the writer before the next decode. No push occurs for flushed or stalled offers.
- Strict FIFO order; no reordering or bypass around entries.

## Timing
- Reset (rst=1 at an edge): count=0, pointers=0, idu_valid=0, witf_push=0, and out_payload reads 0 (storage reset to 0).
- rst=1 mid-operation discards all entries exactly like flush. rst wins over flush.
- Latency: an instruction accepted in cycle t is visible at idu_valid/out_payload in cycle t+1. There is no same-cycle pass-through from input to output.
- Throughput: 1 instruction/cycle sustained for any DEPTH while exu_ready=1. With DEPTH=1 this matches the legacy single-register stage.
- Combinational paths: exu_ready→idu_ready, and isRAW/witf_full/flush→idu_ready. There is no path from in_payload to outputs.
- Stall: with isRAW=1, nothing is accepted, but buffered entries keep draining to the EXU.

## Structure
- Shared package: payload field offsets/widths (PW derived from them), RegAddrBus width 5, and the default DEPTH constant.
- One sub-module, idq_ram: DEPTH×PW register array with one write port (we, waddr, wdata) and one async read port (raddr), with synchronous reset to 0.
- Pointer/count/handshake logic lives in the top module.

## Test plan
- Reset then idle: hold rst 2 cycles, release, ifu_valid=0. Required: count=0, idu_valid=0, idu_ready=1, witf_push=0.
- Fill and drain (DEPTH=2): offer payloads 0xA, 0xB with exu_ready=0. Required: count=2 and idu_ready=0 on the third offer. Then exu_ready=1 with no input: required outputs 0xA then 0xB, then idu_valid=0.
- Full with simultaneous enq/deq: count=2, exu_ready=1, offer 0xC. Required: accepted, count stays 2, and the order observed is head, next, 0xC.
- Hazard stall: isRAW=1 with ifu_valid=1, in_regwr=1, in_rd=5. Required: idu_ready=0, witf_push=0, and buffered entries still dequeue. Drop isRAW: required witf_push=1 with witf_rd=5 in the accept cycle.
- Flush: count=2 and flush=1 together with ifu_valid=1. Required: no accept and no witf_push; next cycle count=0 and idu_valid=0. A following offer 0xD appears at the head after 1 cycle.
- Wrap-around (DEPTH=4): stream 10 instructions with random exu_ready. Required: output sequence equals input sequence, count never exceeds 4, and no lost or duplicated entries.
